// File: rtl/pc_fetch_sequencer_if.sv
// Instruction-memory fetch bus between the PC sequencer (master) and the memory (slave).
interface pc_fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/pc_fetch_sequencer.sv
// MIPS-32 program counter and fetch sequencer: RST -> FETCH -> ISSUE loop.
// It selects the next PC from jr / jump / branch / sequential on each accepted instruction.
module pc_fetch_sequencer #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pc_fetch_sequencer_if.master imem,
    output logic [31:0]          instr,
    output logic                 instr_valid,
    output logic [ADDR_W-1:0]    pc,
    output logic [ADDR_W-1:0]    pc_plus4,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [ADDR_W-1:0]    branch_offset,
    input  logic                 jump,
    input  logic [25:0]          jump_index,
    input  logic                 jr,
    input  logic [ADDR_W-1:0]    jr_addr,
    output logic                 misalign
);

    typedef enum logic [1:0] {
        ST_RST,
        ST_FETCH,
        ST_ISSUE
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [31:0]       instr_q, instr_d;
    logic              misalign_q, misalign_d;

    logic [ADDR_W-1:0] branch_off_bytes;
    logic [ADDR_W-1:0] next_pc;

    assign pc_plus4         = pc_q + ADDR_W'(4);
    assign branch_off_bytes = branch_offset << 2;

    // Redirect priority: jr beats jump beats branch; losers are silently dropped.
    always_comb begin
        if (jr) begin
            next_pc = {jr_addr[ADDR_W-1:2], 2'b00};
        end else if (jump) begin
            next_pc = {pc_plus4[ADDR_W-1 -: 4], jump_index, 2'b00};
        end else if (branch_taken) begin
            next_pc = pc_plus4 + branch_off_bytes;
        end else begin
            next_pc = pc_plus4;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        misalign_d = 1'b0;
        case (state_q)
            ST_RST: begin
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (imem.imem_ack) begin
                    instr_d = imem.imem_rdata;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Redirect inputs only matter in the cycle decode accepts the instruction.
                if (!stall) begin
                    pc_d       = next_pc;
                    misalign_d = jr && (jr_addr[1:0] != 2'b00);
                    state_d    = ST_FETCH;
                end
            end
            default: begin
                state_d = ST_RST;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RST;
            pc_q       <= RESET_PC;
            instr_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            misalign_q <= misalign_d;
        end
    end

    assign imem.imem_req  = (state_q == ST_FETCH);
    assign imem.imem_addr = pc_q;
    assign instr_valid    = (state_q == ST_ISSUE);
    assign instr          = instr_q;
    assign pc             = pc_q;
    assign misalign       = misalign_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed bench for pc_fetch_sequencer: the driver pushes expected fetches to a scoreboard,
// and a monitor pops and compares each one on the cycle decode accepts it.
module tb_pc_fetch_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        mis;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_addr;
    logic        misalign;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    pc_fetch_sequencer_if #(.ADDR_W(32)) bus ();

    pc_fetch_sequencer #(
        .ADDR_W   (32),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem          (bus.master),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .misalign      (misalign)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'h2400_BEEF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1ns after the falling edge; the monitor samples 3ns after it.
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_redirects();
        branch_taken  = 1'b0;
        branch_offset = '0;
        jump          = 1'b0;
        jump_index    = '0;
        jr            = 1'b0;
        jr_addr       = '0;
    endtask

    task automatic issue_one(
        input logic [31:0] exp_pc,
        input int          ack_dly,
        input int          stall_n,
        input logic        j_r,
        input logic [31:0] j_addr,
        input logic        jmp,
        input logic [25:0] jidx,
        input logic        br,
        input logic [31:0] boff,
        input logic        exp_mis
    );
        int n;
        sb_q.push_back('{pc: exp_pc, instr: mem_word(exp_pc), mis: exp_mis});
        n = 0;
        while (!bus.imem_req && n < 20) begin
            step();
            n++;
        end
        check("imem_req_timeout", 32'(bus.imem_req), 32'd1);
        check("imem_addr", bus.imem_addr, exp_pc);
        for (int i = 0; i < ack_dly; i++) begin
            step();
            check("imem_req_held", 32'(bus.imem_req), 32'd1);
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = mem_word(bus.imem_addr);
        step();
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        stall = 1'b1;
        for (int i = 0; i < stall_n; i++) begin
            jr            = i[0];
            jr_addr       = 32'h0BAD_0003;
            jump          = ~i[0];
            jump_index    = 26'h3FF_FFFF;
            branch_taken  = 1'b1;
            branch_offset = 32'h0000_0100;
            step();
            check("stall_pc", pc, exp_pc);
            check("stall_instr", instr, mem_word(exp_pc));
            check("stall_imem_req", 32'(bus.imem_req), 32'd0);
            check("stall_valid", 32'(instr_valid), 32'd1);
        end
        stall         = 1'b0;
        jr            = j_r;
        jr_addr       = j_addr;
        jump          = jmp;
        jump_index    = jidx;
        branch_taken  = br;
        branch_offset = boff;
        step();
        clear_redirects();
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_imem_req"}, 32'(bus.imem_req), 32'd0);
        check({tag, "_instr_valid"}, 32'(instr_valid), 32'd0);
        check({tag, "_instr"}, instr, 32'd0);
        check({tag, "_misalign"}, 32'(misalign), 32'd0);
        check({tag, "_pc"}, pc, RESET_PC);
        check({tag, "_pc_plus4"}, pc_plus4, RESET_PC + 32'd4);
    endtask

    // Monitor: compares each accepted instruction and the misalign pulse that follows it.
    initial begin : monitor
        exp_t e;
        logic pend_mis;
        pend_mis = 1'b0;
        forever begin
            @(negedge clk);
            #3;
            check("misalign", 32'(misalign), 32'(pend_mis));
            pend_mis = 1'b0;
            if (rst_n && instr_valid && !stall) begin
                if (sb_q.size() == 0) begin
                    check("unexpected_issue", pc, 32'hFFFF_FFFF);
                end else begin
                    e = sb_q.pop_front();
                    check("issue_pc", pc, e.pc);
                    check("issue_pc_plus4", pc_plus4, e.pc + 32'd4);
                    check("issue_instr", instr, e.instr);
                    pend_mis = e.mis;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        rst_n          = 1'b0;
        stall          = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;
        clear_redirects();
        step();
        check_reset_values("rst");
        step();
        rst_n = 1'b1;

        //        exp_pc        ack stl jr    jr_addr        jmp   jidx          br    boff           mis
        issue_one(32'h0000_0000, 0, 0, 1'b0, 32'h0,         1'b0, 26'h0,        1'b0, 32'h0,         1'b0);
        issue_one(32'h0000_0004, 0, 0, 1'b0, 32'h0,         1'b0, 26'h0,        1'b0, 32'h0,         1'b0);
        issue_one(32'h0000_0008, 0, 0, 1'b1, 32'h3000_0010, 1'b0, 26'h0,        1'b0, 32'h0,         1'b0);
        issue_one(32'h3000_0010, 0, 0, 1'b0, 32'h0,         1'b1, 26'h0000038,  1'b0, 32'h0,         1'b0);
        issue_one(32'h3000_00E0, 1, 0, 1'b1, 32'h0000_0100, 1'b0, 26'h0,        1'b0, 32'h0,         1'b0);
        issue_one(32'h0000_0100, 0, 0, 1'b0, 32'h0,         1'b0, 26'h0,        1'b1, 32'hFFFF_FFFC, 1'b0);
        issue_one(32'h0000_00F4, 0, 0, 1'b1, 32'h0000_0100, 1'b0, 26'h0,        1'b0, 32'h0,         1'b0);
        issue_one(32'h0000_0100, 0, 0, 1'b0, 32'h0,         1'b0, 26'h0,        1'b1, 32'h0000_0003, 1'b0);
        issue_one(32'h0000_0110, 2, 0, 1'b1, 32'h0040_0006, 1'b1, 26'h0000038,  1'b1, 32'h0000_0003, 1'b1);
        issue_one(32'h0040_0004, 0, 5, 1'b0, 32'h0,         1'b0, 26'h0,        1'b0, 32'h0,         1'b0);
        issue_one(32'h0040_0008, 0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 26'h0,        1'b0, 32'h0,         1'b0);
        issue_one(32'hFFFF_FFFC, 0, 0, 1'b0, 32'h0,         1'b0, 26'h0,        1'b0, 32'h0,         1'b0);
        issue_one(32'h0000_0000, 0, 2, 1'b0, 32'h0,         1'b0, 26'h0,        1'b1, 32'h0000_0003, 1'b0);

        // Abort the fetch of 0x10 with an asynchronous reset while imem_ack is low.
        check("pre_abort_req", 32'(bus.imem_req), 32'd1);
        check("pre_abort_addr", bus.imem_addr, 32'h0000_0010);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_values("abort");
        step();
        step();
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = 32'hBAD0_BAD0;
        rst_n = 1'b1;
        step();
        check("post_rst_valid", 32'(instr_valid), 32'd0);
        check("post_rst_req", 32'(bus.imem_req), 32'd1);
        check("post_rst_addr", bus.imem_addr, RESET_PC);
        check("post_rst_instr", instr, 32'd0);
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = '0;

        issue_one(32'h0000_0000, 0, 0, 1'b0, 32'h0,         1'b0, 26'h0,        1'b0, 32'h0,         1'b0);
        issue_one(32'h0000_0004, 1, 0, 1'b0, 32'h0,         1'b0, 26'h0,        1'b0, 32'h0,         1'b0);

        step();
        step();
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
